// File: rtl/q_table_ctrl_if.sv
// -----------------------------------------------------------------------------
// q_table_ctrl_if
// Handshake and data bundle between a Q-table requester (master) and the
// q_table_ctrl storage/sequencer (slave).
//   start, cur_state, action, next_state : update request and its operands
//   Q_new, q_new_valid                  : write-back value from Q_learning
//   ready, q_valid, done, err           : sequencer status
//   data_out1..9                        : Q(next_state, 0..8)
// -----------------------------------------------------------------------------
interface q_table_ctrl_if #(
    parameter int STATE_W = 6,
    parameter int Q_W     = 16
) ();
    logic               start;
    logic [STATE_W-1:0] cur_state;
    logic [3:0]         action;
    logic [STATE_W-1:0] next_state;
    logic [Q_W-1:0]     Q_new;
    logic               q_new_valid;
    logic               ready;
    logic               q_valid;
    logic               done;
    logic               err;
    logic [Q_W-1:0]     data_out1;
    logic [Q_W-1:0]     data_out2;
    logic [Q_W-1:0]     data_out3;
    logic [Q_W-1:0]     data_out4;
    logic [Q_W-1:0]     data_out5;
    logic [Q_W-1:0]     data_out6;
    logic [Q_W-1:0]     data_out7;
    logic [Q_W-1:0]     data_out8;
    logic [Q_W-1:0]     data_out9;

    modport master (
        output start, cur_state, action, next_state, Q_new, q_new_valid,
        input  ready, q_valid, done, err,
        input  data_out1, data_out2, data_out3, data_out4, data_out5,
        input  data_out6, data_out7, data_out8, data_out9
    );

    modport slave (
        input  start, cur_state, action, next_state, Q_new, q_new_valid,
        output ready, q_valid, done, err,
        output data_out1, data_out2, data_out3, data_out4, data_out5,
        output data_out6, data_out7, data_out8, data_out9
    );
endinterface

// File: rtl/q_table_ctrl.sv
// -----------------------------------------------------------------------------
// q_table_ctrl
// Q-table storage and update sequencer. For each accepted update it fetches the
// nine Q-values of next_state, presents them on data_out1..9, waits for the
// Q_new reply and writes it back to entry (cur_state, action). The table is a
// synchronous single-port array zero-filled by a sweep after every reset.
//
// Ports
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : q_table_ctrl_if.slave (request operands, reply, status, data_out)
//
// Timing (edge E0 = edge that samples an accepted start)
//   READ cycles 0..10 : address k registered at E(k+1), array read at E(k+2),
//                       data_out(k+1) captured at E(k+3)
//   q_valid high from E11; done pulses one cycle after the WRITE cycle.
// -----------------------------------------------------------------------------
module q_table_ctrl #(
    parameter int NUM_STATES = 64,
    parameter int STATE_W    = 6,
    parameter int Q_W        = 16
) (
    input  logic           clock,
    input  logic           reset,
    q_table_ctrl_if.slave  bus
);

    localparam int DEPTH  = NUM_STATES * 9;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [STATE_W:0]   STATE_LIM = (STATE_W + 1)'(NUM_STATES);
    localparam logic [ADDR_W-1:0]  NINE      = ADDR_W'(9);
    localparam logic [3:0]         LAST_RD   = 4'd8;   // last action index issued
    localparam logic [3:0]         RD_DONE   = 4'd10;  // cycle capturing data_out9

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_READ,
        S_PRESENT,
        S_WRITE
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [ADDR_W-1:0]  r_clr_addr;
    logic [ADDR_W-1:0]  r_rd_base;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [3:0]         r_cnt;
    logic [Q_W-1:0]     r_q_new;
    logic [Q_W-1:0]     r_rdata;
    logic [Q_W-1:0]     r_dout [9];
    logic               r_done;
    logic               r_err;

    logic               w_operands_ok;
    logic               w_accept;
    logic               w_mem_we;
    logic [ADDR_W-1:0]  w_mem_addr;
    logic [Q_W-1:0]     w_mem_wdata;

    logic [Q_W-1:0]     r_mem [DEPTH];

    // Operand check uses one extra bit so NUM_STATES == 2**STATE_W still fits.
    assign w_operands_ok = (bus.action <= 4'd8)
                        && ({1'b0, bus.cur_state}  < STATE_LIM)
                        && ({1'b0, bus.next_state} < STATE_LIM);
    assign w_accept      = (r_state == S_IDLE) && bus.start && w_operands_ok;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: every clocked assignment is non-blocking so all registers
        // update from the same pre-edge values, independent of statement order.
        if (reset) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: the default is assigned before the case so no path leaves
        // w_next unassigned, which would otherwise infer a latch.
        w_next = r_state;
        case (r_state)
            S_CLEAR:   if (r_clr_addr == LAST_ADDR) w_next = S_IDLE;
            S_IDLE:    if (w_accept)                w_next = S_READ;
            S_READ:    if (r_cnt == RD_DONE)        w_next = S_PRESENT;
            S_PRESENT: if (bus.q_new_valid)         w_next = S_WRITE;
            S_WRITE:                                w_next = S_IDLE;
            default:                                w_next = S_CLEAR;
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequencing registers and captured outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clr_addr <= '0;
            r_rd_base  <= '0;
            r_rd_addr  <= '0;
            r_wr_addr  <= '0;
            r_cnt      <= '0;
            r_q_new    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                r_dout[k] <= '0;
            end
        end else begin
            r_done <= (r_state == S_WRITE);
            r_err  <= (r_state == S_IDLE) && bus.start && !w_operands_ok;

            if (r_state == S_CLEAR) begin
                r_clr_addr <= r_clr_addr + ADDR_W'(1);
            end

            // Table addresses are formed once from the operands at acceptance;
            // later operand changes are never looked at.
            if (w_accept) begin
                r_rd_base <= ADDR_W'(bus.next_state) * NINE;
                r_wr_addr <= ADDR_W'(bus.cur_state) * NINE + ADDR_W'(bus.action);
                r_cnt     <= '0;
            end

            if (r_state == S_READ) begin
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt <= LAST_RD) begin
                    r_rd_addr <= r_rd_base + ADDR_W'(r_cnt);
                end
                // Address register plus array latency puts each word two
                // cycles behind its issue count.
                if (r_cnt >= 4'd2) begin
                    r_dout[r_cnt - 4'd2] <= r_rdata;
                end
            end

            if ((r_state == S_PRESENT) && bus.q_new_valid) begin
                r_q_new <= bus.Q_new;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Single-port table
    // -------------------------------------------------------------------------
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = r_rd_addr;
        w_mem_wdata = r_q_new;
        case (r_state)
            S_CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_clr_addr;
                w_mem_wdata = '0;
            end
            S_WRITE: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_wr_addr;
            end
            default: ;
        endcase
    end

    // NOTE: the array has no reset branch so it maps onto RAM; the CLEAR sweep
    // after every reset is what zeroes its contents.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
        r_rdata <= r_mem[w_mem_addr];
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.ready     = (r_state == S_IDLE);
    assign bus.q_valid   = (r_state == S_PRESENT);
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.data_out1 = r_dout[0];
    assign bus.data_out2 = r_dout[1];
    assign bus.data_out3 = r_dout[2];
    assign bus.data_out4 = r_dout[3];
    assign bus.data_out5 = r_dout[4];
    assign bus.data_out6 = r_dout[5];
    assign bus.data_out7 = r_dout[6];
    assign bus.data_out8 = r_dout[7];
    assign bus.data_out9 = r_dout[8];

endmodule
